// File: rtl/stream_gen_pkg.sv
// ============================================================================
// stream_gen_pkg : shared encodings for the stream pattern generator
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_POLY = 16'h002D;

endpackage

`default_nettype wire

// File: rtl/stream_pattern_gen_if.sv
// ============================================================================
// stream_pattern_gen_if : valid/ready/last data channel
// Rev 1.0
// ============================================================================
`default_nettype none

interface stream_pattern_gen_if #(
  parameter int DW = 16
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

`default_nettype wire

// File: rtl/stream_pattern_step.sv
// ============================================================================
// stream_pattern_step : combinational next-data function for each pattern mode
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_pattern_step
  import stream_gen_pkg::*;
#(
  parameter int            DW   = 16,
  parameter logic [DW-1:0] POLY = DW'(DEFAULT_POLY)
) (
  input  mode_e         mode_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_INCR:  data_o = data_i + DW'(1);
      // Galois form: shift left, fold the feedback mask in when the MSB falls out
      MODE_LFSR:  data_o = {data_i[DW-2:0], 1'b0} ^ (data_i[DW-1] ? POLY : '0);
      MODE_CONST: data_o = data_i;
      MODE_WALK:  data_o = {data_i[DW-2:0], data_i[DW-1]};
      default:    data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stream_pattern_gen.sv
// ============================================================================
// stream_pattern_gen : programmable patterned burst source on a valid/ready channel
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_pattern_gen
  import stream_gen_pkg::*;
#(
  parameter int            DW   = 16,
  parameter int            GAPW = 8,
  parameter int            LENW = 16,
  parameter logic [DW-1:0] POLY = DW'(DEFAULT_POLY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic [GAPW-1:0]      cfg_gap_i,
  input  logic [LENW-1:0]      cfg_len_i,
  input  logic [DW-1:0]        cfg_seed_i,
  stream_pattern_gen_if.master down,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LENW-1:0]      beat_cnt_o
);

  state_e          state_q;
  mode_e           mode_q;
  logic [GAPW-1:0] gap_q;
  logic [GAPW-1:0] gap_cnt_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] beat_cnt_q;
  logic [LENW-1:0] beat_cnt_d;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   data_d;
  logic [DW-1:0]   seed_d;
  logic            valid_q;
  logic            last_q;
  logic            busy_q;
  logic            done_q;
  logic            stop_pend_q;

  mode_e cfg_mode;
  logic  handshake;
  logic  last_cur;
  logic  last_nxt;
  logic  end_run;

  stream_pattern_step #(
    .DW   (DW),
    .POLY (POLY)
  ) u_step (
    .mode_i (mode_q),
    .data_i (data_q),
    .data_o (data_d)
  );

  assign cfg_mode   = mode_e'(cfg_mode_i);
  // An all-zero LFSR state would never leave zero
  assign seed_d     = (cfg_mode == MODE_LFSR && cfg_seed_i == '0) ? DW'(1) : cfg_seed_i;
  assign beat_cnt_d = beat_cnt_q + LENW'(1);
  assign handshake  = valid_q && down.ready;
  assign last_cur   = (len_q != '0) && (beat_cnt_q == len_q - LENW'(1));
  assign last_nxt   = (len_q != '0) && (beat_cnt_d == len_q - LENW'(1));
  assign end_run    = last_q || stop_pend_q || stop_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_INCR;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            mode_q      <= cfg_mode;
            gap_q       <= cfg_gap_i;
            len_q       <= cfg_len_i;
            data_q      <= seed_d;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b1;
            stop_pend_q <= 1'b0;
            if (cfg_gap_i != '0) begin
              gap_cnt_q <= cfg_gap_i;
              state_q   <= ST_GAP;
            end else begin
              state_q <= ST_SEND;
              valid_q <= 1'b1;
              last_q  <= (cfg_len_i == LENW'(1));
            end
          end
        end
        ST_GAP: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == GAPW'(1)) begin
            state_q <= ST_SEND;
            valid_q <= 1'b1;
            last_q  <= last_cur;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAPW'(1);
          end
        end
        ST_SEND: begin
          if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
          // valid/data/last only move on an accepted beat
          if (handshake) begin
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            if (end_run) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (gap_q != '0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_q;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
            end else begin
              last_q <= last_nxt;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign down.valid = valid_q;
  assign down.data  = data_q;
  assign down.last  = last_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign beat_cnt_o = beat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_pattern_gen.sv
// ============================================================================
// tb_stream_pattern_gen : scoreboard bench with a behavioural pattern model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_pattern_gen;

  localparam int          DW   = 16;
  localparam int          GAPW = 8;
  localparam int          LENW = 16;
  localparam logic [15:0] POLY = 16'h002D;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [1:0]      cfg_mode = '0;
  logic [GAPW-1:0] cfg_gap = '0;
  logic [LENW-1:0] cfg_len = '0;
  logic [DW-1:0]   cfg_seed = '0;
  logic            busy;
  logic            done;
  logic [LENW-1:0] beat_cnt;

  stream_pattern_gen_if #(.DW(DW)) down_if ();

  stream_pattern_gen #(
    .DW   (DW),
    .GAPW (GAPW),
    .LENW (LENW),
    .POLY (POLY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .stop_i     (stop),
    .cfg_mode_i (cfg_mode),
    .cfg_gap_i  (cfg_gap),
    .cfg_len_i  (cfg_len),
    .cfg_seed_i (cfg_seed),
    .down       (down_if.master),
    .busy_o     (busy),
    .done_o     (done),
    .beat_cnt_o (beat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];

  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   ref_cyc = 0;
  int   gap_cur = 0;
  int   rmode = 0;
  bit   expect_valid_next = 1'b0;
  logic ready_val = 1'b1;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] model_next(input int mode, input logic [DW-1:0] d);
    case (mode)
      0:       return d + 16'd1;
      1:       return (d << 1) ^ ((d >= 16'h8000) ? POLY : 16'h0000);
      2:       return d;
      default: return (d << 1) | (d >> 15);
    endcase
  endfunction

  // ready driver: held value or coin flip each cycle
  always @(posedge clk) begin
    #1;
    if (rmode != 0) down_if.ready = 1'($urandom_range(0, 1));
    else            down_if.ready = ready_val;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (expect_valid_next) chk("b2b_valid", 64'(down_if.valid), 64'd1);
      expect_valid_next = 1'b0;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 64'(down_if.valid), 64'd1);
        chk("hold_data", 64'(down_if.data), 64'(prev_data));
        chk("hold_last", 64'(down_if.last), 64'(prev_last));
      end
      if (down_if.valid && !prev_valid) begin
        chk("valid_has_beat", 64'(exp_q.size() != 0), 64'd1);
        chk("valid_rise_cycle", 64'(cyc), 64'(ref_cyc + gap_cur));
      end
      if (down_if.valid && down_if.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(down_if.data), 64'(e.data));
          chk("beat_last", 64'(down_if.last), 64'(e.last));
        end
        ref_cyc = cyc + 1;
        expect_valid_next = (gap_cur == 0) && (exp_q.size() > 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_valid", 64'(down_if.valid), 64'd0);
        chk("done_cycle", 64'(cyc), 64'(ref_cyc));
      end
    end
    prev_valid = down_if.valid;
    prev_ready = down_if.ready;
    prev_data  = down_if.data;
    prev_last  = down_if.last;
  end

  // Called at posedge+1: programs config, queues the model's beats, pulses start
  task automatic begin_run(input int mode, input logic [DW-1:0] seed, input int len,
                           input int gap, input int nexp);
    logic [DW-1:0] d;
    cfg_mode = 2'(mode);
    cfg_seed = seed;
    cfg_len  = LENW'(len);
    cfg_gap  = GAPW'(gap);
    gap_cur  = gap;
    d = (mode == 1 && seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back('{data: d, last: (len != 0 && i == len - 1)});
      d = model_next(mode, d);
    end
    start   = 1'b1;
    ref_cyc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_run(input int nbeats, input int base);
    int t = 0;
    while (done_cnt == base && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("run_done_seen", 64'(done_cnt != base), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt), 64'(base + 1));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("final_beat_cnt", 64'(beat_cnt), 64'(nbeats));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!down_if.valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("valid_seen", 64'(down_if.valid), 64'd1);
  endtask

  task automatic reset_mid_run(input int base);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(down_if.valid), 64'd0);
    chk("rst_data", 64'(down_if.data), 64'd0);
    chk("rst_last", 64'(down_if.last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt), 64'(base));
  endtask

  initial begin
    int base;
    down_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_valid", 64'(down_if.valid), 64'd0);
    chk("reset_data", 64'(down_if.data), 64'd0);
    chk("reset_last", 64'(down_if.last), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // INCR wrap across zero, back-to-back beats
    base = done_cnt; begin_run(0, 16'hFFFE, 4, 0, 4); finish_run(4, base);
    // INCR with two idle cycles before every beat
    base = done_cnt; begin_run(0, 16'h0005, 3, 2, 3); finish_run(3, base);
    // LFSR zero seed substitution and feedback fold
    base = done_cnt; begin_run(1, 16'h0000, 3, 0, 3); finish_run(3, base);
    base = done_cnt; begin_run(1, 16'h8000, 2, 0, 2); finish_run(2, base);
    // CONST under random backpressure
    rmode = 1;
    base = done_cnt; begin_run(2, 16'hA5A5, 10, 0, 10); finish_run(10, base);
    rmode = 0;

    // WALK unbounded, stop while the first beat is stalled
    ready_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = done_cnt;
    begin_run(3, 16'h0001, 0, 0, 1);
    wait_valid();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_val = 1'b1;
    finish_run(1, base);
    repeat (10) @(posedge clk);
    #1;
    chk("stop_stays_idle", 64'(busy), 64'd0);

    // reset during GAP
    base = done_cnt;
    begin_run(0, 16'h1234, 3, 5, 3);
    repeat (2) @(posedge clk);
    #1;
    reset_mid_run(base);

    // reset during SEND with the beat stalled
    ready_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = done_cnt;
    begin_run(2, 16'h00FF, 4, 3, 4);
    wait_valid();
    reset_mid_run(base);
    ready_val = 1'b1;
    @(posedge clk); #1;

    // start and config changes while busy are ignored
    base = done_cnt;
    begin_run(0, 16'd100, 6, 1, 6);
    repeat (3) @(posedge clk);
    #1;
    cfg_mode = 2'd2; cfg_seed = 16'hBEEF; cfg_gap = '0; cfg_len = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_run(6, base);

    // start and stop together in IDLE: nothing happens
    base = done_cnt;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("startstop_valid", 64'(down_if.valid), 64'd0);
    chk("startstop_no_done", 64'(done_cnt), 64'(base));

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      int m, l, g;
      logic [DW-1:0] s;
      m = int'($urandom_range(0, 3));
      s = 16'($urandom);
      l = int'($urandom_range(1, 12));
      g = int'($urandom_range(0, 3));
      rmode = int'($urandom_range(0, 1));
      base = done_cnt;
      begin_run(m, s, l, g, l);
      finish_run(l, base);
      rmode = 0;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/stream_pattern_gen.md
# stream_pattern_gen

Parametrised valid/ready stream source for block-level benches and on-chip self-test. It emits bursts of patterned data: incrementing, LFSR, constant or walking-bit. Burst length, inter-beat gap and seed are runtime-programmable and latched at start. It drives one downstream valid/ready channel, obeys strict handshake rules, and reports busy/done status plus an accepted-beat count.

## Interface
- DW, 16, data width (≥2)
- GAPW, 8, width of gap configuration
- LENW, 16, width of burst length and beat counter
- POLY, 16'h002D, Galois LFSR feedback mask (DW bits)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle run request; ignored while busy
- stop  in  1  single-cycle abort request
- cfg_mode  in  2  0 INCR, 1 LFSR, 2 CONST, 3 WALK
- cfg_gap  in  GAPW  idle cycles before each beat
- cfg_len  in  LENW  beats per run; 0 = unbounded
- cfg_seed  in  DW  first data value
- down_valid  out  1  beat available
- down_ready  in  1  downstream accepts
- down_data  out  DW  beat payload
- down_last  out  1  final beat of a bounded run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when a run ends
- beat_cnt  out  LENW  beats accepted in current/last run

## Operation
- FSM states: IDLE, GAP, SEND.
- IDLE + start (no stop): latch mode/gap/len, load data with seed, clear beat_cnt, set busy. Go to GAP if cfg_gap≠0 (gap counter = cfg_gap), else go to SEND.
- LFSR mode with seed 0: load 1 instead (no lock-up).
- GAP: decrement the counter each cycle; at 1, go to SEND.
- SEND: down_valid=1. down_data and down_last are held stable until the handshake (valid&&ready).
- On handshake: beat_cnt+1 (wraps), advance data. If final beat or stop pending: go to IDLE, pulse done, clear busy. Else go to GAP (gap≠0) or stay in SEND (gap=0).
- Data advance rules:
  - INCR: d+1 mod 2^DW.
  - LFSR: (d<<1) ^ (d[DW-1] ? POLY : 0).
  - CONST: d.
  - WALK: rotate left 1.
- down_last = SEND && len≠0 && beat_cnt==len-1.
- stop in GAP: go to IDLE next cycle, done pulses.
- stop in SEND: set stop-pending. Valid never drops without a handshake; the run ends after the current beat is accepted.
- stop in IDLE: ignored. start+stop in the same IDLE cycle: stop wins, start ignored, no done.
- Config inputs changed mid-run have no effect.
- Unbounded run (len=0): ends only on stop; beat_cnt wraps silently.

## Timing
- Reset values: down_valid 0, down_data 0, down_last 0, busy 0, done 0, beat_cnt 0, state IDLE.
- All outputs are registered; no combinational path from down_ready to any output.
- start sampled at edge k: busy=1 from k+1; first down_valid at k+1+cfg_gap.
- gap=0: one beat per cycle while ready is held high.
- gap=G: after the handshake at edge e, valid is low for exactly G cycles and high again from e+G+1.
- Final handshake at edge e: done=1, busy=0, valid=0 during the cycle after e. start is accepted again in that same cycle.
- rst mid-run: all outputs return to reset values at the next edge; no done pulse.

## Structure
- Package stream_gen_pkg holds:
  - mode encodings MODE_INCR/LFSR/CONST/WALK
  - FSM state enum
  - default POLY constant
- Sub-module stream_pattern_step: combinational next-value function (mode, d, POLY → d_next), reused by checker models.
- The top level contains the FSM, gap counter, beat counter and output registers.

## Test plan
- INCR, seed 16'hFFFE, len 4, gap 0, ready=1 → data FFFE, FFFF, 0000, 0001 on four consecutive cycles; last on 0001; done one cycle later; beat_cnt=4.
- INCR, seed 5, len 3, gap 2, ready=1 → valid pattern 0,0,1,0,0,1,0,0,1 after start; data 5,6,7.
- LFSR, seed 0, len 3 → data 0001, 0002, 0004. Then seed 16'h8000 → second beat 16'h002D.
- Ready toggled randomly (~50%), CONST seed 16'hA5A5, len 10 → data/last never change while valid&&!ready; exactly 10 beats; done once.
- WALK, seed 1, len 0, gap 0, stop asserted while valid&&!ready → current beat 0x0001 held until accepted, then busy=0 and done pulse; no further valid.
- rst asserted during GAP and during SEND → all outputs reset next cycle, no done. start asserted while busy → ignored, run continues unchanged.
